// File: rtl/core_pkg.sv
// Shared core definitions: instruction classes, load/store funct3 codes,
// MEM-stage FSM encoding and byte-lane helpers.
package core_pkg;

    localparam logic [1:0] INST_EX  = 2'b00;
    localparam logic [1:0] INST_MEM = 2'b01;
    localparam logic [1:0] INST_WB  = 2'b10;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int unsigned CNT_W = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    // Attributes of the in-flight access needed when the ack returns.
    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } access_t;

    // Unsupported sizes (funct3[1:0] == 11) are reported as misaligned.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_sel(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] sel;
        case (funct3[1:0])
            2'b00:   sel = 4'b0001 << addr_lo;
            2'b01:   sel = 4'b0011 << addr_lo;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] store_repl(input logic [2:0] funct3, input logic [31:0] sdat);
        logic [31:0] d;
        case (funct3[1:0])
            2'b00:   d = {4{sdat[7:0]}};
            2'b01:   d = {2{sdat[15:0]}};
            default: d = sdat;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select with sign/zero extension for byte, halfword and word loads.
module load_align
    import core_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = data[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? data[31:16] : data[15:0];
        result = data;
        case (funct3[1:0])
            2'b00:   result = funct3[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   result = funct3[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: captures EX results and runs aligned
// Wishbone-classic loads/stores, publishing MEM_* results for forwarding.
module mem_stage_lsu
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        ex_rd,
    input  logic [1:0]        ex_inst,
    input  logic              ex_we,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_dat,
    input  logic [31:0]       ex_sdat,
    output logic [4:0]        MEM_rd,
    output logic [1:0]        MEM_inst,
    output logic [31:0]       MEM_dat,
    output logic              mem_ack,
    output logic              mem_err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [3:0]        wb_sel_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    access_t           acc_q, acc_d;
    logic [4:0]        mem_rd_d;
    logic [1:0]        mem_inst_d;
    logic [31:0]       mem_dat_d;
    logic              mem_ack_d, mem_err_d;
    logic              cyc_d, stb_d, we_d;
    logic [ADDR_W-1:0] adr_d;
    logic [3:0]        sel_d;
    logic [31:0]       wdat_d;
    logic [31:0]       load_data;

    load_align u_load_align (
        .data    (wb_dat_i),
        .addr_lo (acc_q.addr_lo),
        .funct3  (acc_q.funct3),
        .result  (load_data)
    );

    assign in_ready = (state_q == IDLE);

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        mem_rd_d   = MEM_rd;
        mem_inst_d = MEM_inst;
        mem_dat_d  = MEM_dat;
        mem_ack_d  = mem_ack;
        mem_err_d  = 1'b0;
        cyc_d      = wb_cyc_o;
        stb_d      = wb_stb_o;
        we_d       = wb_we_o;
        adr_d      = wb_adr_o;
        sel_d      = wb_sel_o;
        wdat_d     = wb_dat_o;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mem_rd_d   = ex_rd;
                    mem_inst_d = ex_inst;
                    mem_dat_d  = ex_dat;
                    mem_ack_d  = 1'b0;
                    if (ex_inst == INST_MEM) begin
                        if (is_misaligned(ex_funct3, ex_dat[1:0])) begin
                            mem_dat_d = 32'h0;
                            mem_ack_d = 1'b1;
                            mem_err_d = 1'b1;
                        end else begin
                            state_d = BUS;
                            count_d = '0;
                            acc_d   = '{we: ex_we, funct3: ex_funct3, addr_lo: ex_dat[1:0]};
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            we_d    = ex_we;
                            adr_d   = ADDR_W'({ex_dat[31:2], 2'b00});
                            sel_d   = lane_sel(ex_funct3, ex_dat[1:0]);
                            wdat_d  = store_repl(ex_funct3, ex_sdat);
                        end
                    end
                end else begin
                    mem_rd_d   = 5'd0;
                    mem_inst_d = INST_EX;
                    mem_ack_d  = 1'b0;
                end
            end
            BUS: begin
                if (wb_ack_i || (count_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d   = IDLE;
                    mem_ack_d = 1'b1;
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    adr_d     = '0;
                    sel_d     = 4'b0;
                    wdat_d    = 32'h0;
                    // Ack wins over a timeout landing on the same edge.
                    if (wb_ack_i) begin
                        if (!acc_q.we) begin
                            mem_dat_d = load_data;
                        end
                    end else begin
                        mem_dat_d = 32'h0;
                        mem_err_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            MEM_rd   <= 5'd0;
            MEM_inst <= 2'b00;
            MEM_dat  <= 32'h0;
            mem_ack  <= 1'b0;
            mem_err  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_sel_o <= 4'b0;
            wb_dat_o <= 32'h0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            MEM_rd   <= mem_rd_d;
            MEM_inst <= mem_inst_d;
            MEM_dat  <= mem_dat_d;
            mem_ack  <= mem_ack_d;
            mem_err  <= mem_err_d;
            wb_cyc_o <= cyc_d;
            wb_stb_o <= stb_d;
            wb_we_o  <= we_d;
            wb_adr_o <= adr_d;
            wb_sel_o <= sel_d;
            wb_dat_o <= wdat_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: inputs driven and outputs sampled on the
// falling edge; expected values are hand-computed constants.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_inst;
    logic        ex_we;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_dat;
    logic [31:0] ex_sdat;
    logic [4:0]  MEM_rd;
    logic [1:0]  MEM_inst;
    logic [31:0] MEM_dat;
    logic        mem_ack;
    logic        mem_err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ex_rd(ex_rd), .ex_inst(ex_inst), .ex_we(ex_we), .ex_funct3(ex_funct3),
        .ex_dat(ex_dat), .ex_sdat(ex_sdat),
        .MEM_rd(MEM_rd), .MEM_inst(MEM_inst), .MEM_dat(MEM_dat),
        .mem_ack(mem_ack), .mem_err(mem_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    // Present one instruction for a single edge; returns on the next falling edge.
    task automatic issue(input logic [1:0] inst, input logic [4:0] rd, input logic we,
                         input logic [2:0] f3, input logic [31:0] dat, input logic [31:0] sdat);
        in_valid  = 1'b1;
        ex_inst   = inst;
        ex_rd     = rd;
        ex_we     = we;
        ex_funct3 = f3;
        ex_dat    = dat;
        ex_sdat   = sdat;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic bus_ack(input logic [31:0] rdata);
        wb_dat_i = rdata;
        wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({MEM_rd, MEM_inst, MEM_dat, mem_ack, mem_err} !== 41'h0) begin
            errors++; $display("FAIL reset_mem got rd=%0d inst=%b dat=%h ack=%b err=%b exp all 0", MEM_rd, MEM_inst, MEM_dat, mem_ack, mem_err);
        end
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o} !== 71'h0) begin
            errors++; $display("FAIL reset_wb got cyc=%b stb=%b we=%b adr=%h sel=%b dat=%h exp all 0", wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lw;
        issue(2'b01, 5'd5, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b110) begin errors++; $display("FAIL lw_ctl got=%b exp=110", {wb_cyc_o, wb_stb_o, wb_we_o}); end
        checks++;
        if (wb_sel_o !== 4'b1111) begin errors++; $display("FAIL lw_sel got=%b exp=1111", wb_sel_o); end
        checks++;
        if (wb_adr_o !== 32'h100) begin errors++; $display("FAIL lw_adr got=%h exp=00000100", wb_adr_o); end
        checks++;
        if ({in_ready, mem_ack} !== 2'b00) begin errors++; $display("FAIL lw_busy got ready/ack=%b exp=00", {in_ready, mem_ack}); end
        bus_ack(32'hDEAD_BEEF);
        checks++;
        if (MEM_dat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_dat got=%h exp=deadbeef", MEM_dat); end
        checks++;
        if ({mem_ack, mem_err, MEM_rd, MEM_inst} !== {1'b1, 1'b0, 5'd5, 2'b01}) begin
            errors++; $display("FAIL lw_res got ack=%b err=%b rd=%0d inst=%b exp ack=1 err=0 rd=5 inst=01", mem_ack, mem_err, MEM_rd, MEM_inst);
        end
        checks++;
        if ({wb_cyc_o, wb_stb_o, in_ready} !== 3'b001) begin errors++; $display("FAIL lw_done got cyc/stb/ready=%b exp=001", {wb_cyc_o, wb_stb_o, in_ready}); end
        @(negedge clk);
        checks++;
        if ({mem_ack, MEM_rd} !== 6'd0) begin errors++; $display("FAIL lw_bubble got ack=%b rd=%0d exp ack=0 rd=0", mem_ack, MEM_rd); end
    endtask

    task automatic test_lb_lbu;
        issue(2'b01, 5'd6, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
        checks++;
        if (wb_sel_o !== 4'b1000) begin errors++; $display("FAIL lb_sel got=%b exp=1000", wb_sel_o); end
        checks++;
        if (wb_adr_o !== 32'h100) begin errors++; $display("FAIL lb_adr got=%h exp=00000100", wb_adr_o); end
        bus_ack(32'h80FF_FF7F);
        checks++;
        if (MEM_dat !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_dat got=%h exp=ffffff80", MEM_dat); end
        issue(2'b01, 5'd6, 1'b0, 3'b100, 32'h0000_0103, 32'h0);
        bus_ack(32'h80FF_FF7F);
        checks++;
        if (MEM_dat !== 32'h0000_0080) begin errors++; $display("FAIL lbu_dat got=%h exp=00000080", MEM_dat); end
        issue(2'b01, 5'd7, 1'b0, 3'b001, 32'h0000_0102, 32'h0);
        checks++;
        if (wb_sel_o !== 4'b1100) begin errors++; $display("FAIL lh_sel got=%b exp=1100", wb_sel_o); end
        bus_ack(32'h80FF_FF7F);
        checks++;
        if (MEM_dat !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_dat got=%h exp=ffff80ff", MEM_dat); end
        issue(2'b01, 5'd7, 1'b0, 3'b101, 32'h0000_0100, 32'h0);
        bus_ack(32'h80FF_FF7F);
        checks++;
        if (MEM_dat !== 32'h0000_FF7F) begin errors++; $display("FAIL lhu_dat got=%h exp=0000ff7f", MEM_dat); end
    endtask

    task automatic test_sh;
        issue(2'b01, 5'd0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111) begin errors++; $display("FAIL sh_ctl got=%b exp=111", {wb_cyc_o, wb_stb_o, wb_we_o}); end
        checks++;
        if (wb_sel_o !== 4'b1100) begin errors++; $display("FAIL sh_sel got=%b exp=1100", wb_sel_o); end
        checks++;
        if (wb_dat_o !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdat got=%h exp=abcdabcd", wb_dat_o); end
        checks++;
        if (wb_adr_o !== 32'h200) begin errors++; $display("FAIL sh_adr got=%h exp=00000200", wb_adr_o); end
        @(negedge clk);
        checks++;
        if ({in_ready, wb_cyc_o} !== 2'b01) begin errors++; $display("FAIL sh_wait got ready/cyc=%b exp=01", {in_ready, wb_cyc_o}); end
        bus_ack(32'hFFFF_FFFF);
        checks++;
        if ({in_ready, mem_ack, wb_cyc_o} !== 3'b110) begin errors++; $display("FAIL sh_done got ready/ack/cyc=%b exp=110", {in_ready, mem_ack, wb_cyc_o}); end
        checks++;
        if (MEM_dat !== 32'h0000_0202) begin errors++; $display("FAIL sh_dat got=%h exp=00000202", MEM_dat); end
        issue(2'b01, 5'd0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_005A);
        checks++;
        if ({wb_sel_o, wb_dat_o} !== {4'b0010, 32'h5A5A_5A5A}) begin errors++; $display("FAIL sb_lane got sel=%b dat=%h exp sel=0010 dat=5a5a5a5a", wb_sel_o, wb_dat_o); end
        bus_ack(32'h0);
    endtask

    task automatic test_misaligned;
        issue(2'b01, 5'd9, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
        checks++;
        if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin errors++; $display("FAIL mis_cyc got=%b exp=00", {wb_cyc_o, wb_stb_o}); end
        checks++;
        if ({mem_err, mem_ack, in_ready} !== 3'b111) begin errors++; $display("FAIL mis_flags got err/ack/ready=%b exp=111", {mem_err, mem_ack, in_ready}); end
        checks++;
        if (MEM_dat !== 32'h0) begin errors++; $display("FAIL mis_dat got=%h exp=00000000", MEM_dat); end
        @(negedge clk);
        checks++;
        if (mem_err !== 1'b0) begin errors++; $display("FAIL mis_pulse got=%b exp=0", mem_err); end
        issue(2'b01, 5'd9, 1'b0, 3'b001, 32'h0000_0103, 32'h0);
        checks++;
        if ({wb_cyc_o, mem_err} !== 2'b01) begin errors++; $display("FAIL mis_half got cyc/err=%b exp=01", {wb_cyc_o, mem_err}); end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int busy;
        bit dropped;
        busy = 0;
        dropped = 1'b0;
        issue(2'b01, 5'd4, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        for (int i = 0; i < 20 && !dropped; i++) begin
            if (wb_cyc_o) begin
                busy++;
                @(negedge clk);
            end else begin
                dropped = 1'b1;
            end
        end
        checks++;
        if (!dropped || busy != 4) begin errors++; $display("FAIL to_cycles got busy=%0d dropped=%b exp busy=4 dropped=1", busy, dropped); end
        checks++;
        if ({mem_err, mem_ack, in_ready} !== 3'b111) begin errors++; $display("FAIL to_flags got err/ack/ready=%b exp=111", {mem_err, mem_ack, in_ready}); end
        checks++;
        if (MEM_dat !== 32'h0) begin errors++; $display("FAIL to_dat got=%h exp=00000000", MEM_dat); end
        @(negedge clk);
        checks++;
        if (mem_err !== 1'b0) begin errors++; $display("FAIL to_pulse got=%b exp=0", mem_err); end
    endtask

    task automatic test_ack_wins;
        issue(2'b01, 5'd8, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        repeat (3) @(negedge clk);
        checks++;
        if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL aw_cyc got=%b exp=1", wb_cyc_o); end
        bus_ack(32'h1122_3344);
        checks++;
        if ({mem_err, mem_ack, MEM_dat} !== {1'b0, 1'b1, 32'h1122_3344}) begin
            errors++; $display("FAIL aw_res got err=%b ack=%b dat=%h exp err=0 ack=1 dat=11223344", mem_err, mem_ack, MEM_dat);
        end
        // A stray ack while idle must not produce a result.
        bus_ack(32'hFFFF_FFFF);
        checks++;
        if ({mem_ack, wb_cyc_o, in_ready} !== 3'b001) begin errors++; $display("FAIL idle_ack got ack/cyc/ready=%b exp=001", {mem_ack, wb_cyc_o, in_ready}); end
    endtask

    task automatic test_reset_mid_then_alu;
        issue(2'b01, 5'd2, 1'b0, 3'b010, 32'h0000_0500, 32'h0);
        checks++;
        if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL rm_cyc got=%b exp=1", wb_cyc_o); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o} !== 39'h0) begin errors++; $display("FAIL rm_wb got cyc=%b stb=%b sel=%b adr=%h exp all 0", wb_cyc_o, wb_stb_o, wb_sel_o, wb_adr_o); end
        checks++;
        if ({MEM_rd, MEM_inst, MEM_dat, mem_ack, mem_err, in_ready} !== 42'h1) begin
            errors++; $display("FAIL rm_mem got rd=%0d inst=%b dat=%h ack=%b err=%b ready=%b exp 0s ready=1", MEM_rd, MEM_inst, MEM_dat, mem_ack, mem_err, in_ready);
        end
        issue(2'b00, 5'd3, 1'b0, 3'b000, 32'h0000_0007, 32'h0);
        checks++;
        if ({MEM_inst, MEM_dat, mem_ack, MEM_rd} !== {2'b00, 32'h7, 1'b0, 5'd3}) begin
            errors++; $display("FAIL alu_res got inst=%b dat=%h ack=%b rd=%0d exp inst=00 dat=00000007 ack=0 rd=3", MEM_inst, MEM_dat, mem_ack, MEM_rd);
        end
        checks++;
        if ({wb_cyc_o, in_ready} !== 2'b01) begin errors++; $display("FAIL alu_nobus got cyc/ready=%b exp=01", {wb_cyc_o, in_ready}); end
        issue(2'b10, 5'd12, 1'b0, 3'b000, 32'hCAFE_0001, 32'h0);
        checks++;
        if ({MEM_inst, MEM_dat, mem_ack, wb_cyc_o} !== {2'b10, 32'hCAFE_0001, 1'b0, 1'b0}) begin
            errors++; $display("FAIL wb_res got inst=%b dat=%h ack=%b cyc=%b exp inst=10 dat=cafe0001 ack=0 cyc=0", MEM_inst, MEM_dat, mem_ack, wb_cyc_o);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; ex_rd = '0; ex_inst = '0; ex_we = 1'b0;
        ex_funct3 = '0; ex_dat = '0; ex_sdat = '0; wb_dat_i = '0; wb_ack_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_misaligned();
        test_timeout();
        test_ack_wins();
        test_reset_mid_then_alu();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
